// File: rtl/rf_ctrl_burst_if.sv
// Command, write-beat and read-beat handshake bundle for rf_ctrl_burst.
// Each channel transfers on a rising edge where its VALID and READY are both high; VALID holds its payload until then.
interface rf_ctrl_burst_if #(
    parameter int ADDR_WIDTH       = 8,
    parameter int LC_RF_DATA_WIDTH = 24
);
    logic                        CMD_VALID;
    logic                        CMD_READY;
    logic                        CMD_WR;
    logic [ADDR_WIDTH-1:0]       CMD_ADDR;
    logic [ADDR_WIDTH-1:0]       CMD_LEN;
    logic                        IN_VALID;
    logic                        IN_READY;
    logic [LC_RF_DATA_WIDTH-1:0] IN_DATA;
    logic                        OUT_VALID;
    logic                        OUT_READY;
    logic [LC_RF_DATA_WIDTH-1:0] OUT_DATA;

    modport master (
        output CMD_VALID, CMD_WR, CMD_ADDR, CMD_LEN, IN_VALID, IN_DATA, OUT_READY,
        input  CMD_READY, IN_READY, OUT_VALID, OUT_DATA
    );

    modport slave (
        input  CMD_VALID, CMD_WR, CMD_ADDR, CMD_LEN, IN_VALID, IN_DATA, OUT_READY,
        output CMD_READY, IN_READY, OUT_VALID, OUT_DATA
    );
endinterface

// File: rtl/rf_ctrl_burst.sv
// Layer-controller register file with auto-incrementing burst read/write and a flat DOUT image.
// Optional RF_CTRL_WRITE_PROTECT_EN adds WP_MASK, which blocks writes to masked registers.
module rf_ctrl_burst #(
    parameter int RF_DEPTH         = 256,
    parameter int LC_RF_DATA_WIDTH = 24,
    parameter int ADDR_WIDTH       = 8
) (
    input  logic                                 CLK,
    input  logic                                 RESETn,
    rf_ctrl_burst_if.slave                       bus,
    output logic                                 DONE,
    output logic                                 ERR,
    output logic [RF_DEPTH-1:0]                  UPDATED,
    output logic [LC_RF_DATA_WIDTH*RF_DEPTH-1:0] DOUT,
`ifdef RF_CTRL_WRITE_PROTECT_EN
    input  logic [RF_DEPTH-1:0]                  WP_MASK,
`endif
    output logic [1:0]                           STATE
);
    localparam int IW = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    logic [1:0]                  state;
    logic [ADDR_WIDTH-1:0]       addr;
    logic [ADDR_WIDTH-1:0]       cnt;
    logic [ADDR_WIDTH-1:0]       next_addr;
    logic [IW-1:0]               wr_idx;
    logic                        wp_hit;
    logic                        wr_ok;
    logic                        out_valid;
    logic [LC_RF_DATA_WIDTH-1:0] out_data;
    logic [LC_RF_DATA_WIDTH-1:0] rf [RF_DEPTH];

    // The extra top bit keeps the compare correct when RF_DEPTH == 2^ADDR_WIDTH.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < (ADDR_WIDTH+1)'(RF_DEPTH);
    endfunction

    function automatic logic [LC_RF_DATA_WIDTH-1:0] rd(input logic [ADDR_WIDTH-1:0] a);
        return in_range(a) ? rf[a[IW-1:0]] : '0;
    endfunction

    assign next_addr     = addr + 1'b1;
    assign wr_idx        = addr[IW-1:0];
    assign bus.CMD_READY = (state == IDLE);
    assign bus.IN_READY  = (state == WRITE);
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_DATA  = out_data;
    assign DONE          = (state == FIN);
    assign STATE         = state;

    always_comb begin
        wp_hit = 1'b0;
`ifdef RF_CTRL_WRITE_PROTECT_EN
        wp_hit = in_range(addr) & WP_MASK[wr_idx];
`endif
        wr_ok = in_range(addr) & ~wp_hit;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= IDLE;
            addr      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ERR       <= 1'b0;
            UPDATED   <= '0;
            for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
        end else begin
            UPDATED <= '0;
            case (state)
                IDLE: begin
                    if (bus.CMD_VALID) begin
                        addr <= bus.CMD_ADDR;
                        cnt  <= bus.CMD_LEN;
                        ERR  <= 1'b0;
                        if (bus.CMD_WR) begin
                            state <= WRITE;
                        end else begin
                            // First read beat is registered straight off the command.
                            state     <= READ;
                            out_valid <= 1'b1;
                            out_data  <= rd(bus.CMD_ADDR);
                            if (!in_range(bus.CMD_ADDR)) ERR <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.IN_VALID) begin
                        if (wr_ok) begin
                            rf[wr_idx]      <= bus.IN_DATA;
                            UPDATED[wr_idx] <= 1'b1;
                        end else begin
                            ERR <= 1'b1;
                        end
                        addr <= next_addr;
                        if (cnt == '0) state <= FIN;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                READ: begin
                    if (out_valid && bus.OUT_READY) begin
                        if (cnt == '0) begin
                            out_valid <= 1'b0;
                            state     <= FIN;
                        end else begin
                            cnt      <= cnt - 1'b1;
                            addr     <= next_addr;
                            out_data <= rd(next_addr);
                            if (!in_range(next_addr)) ERR <= 1'b1;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < RF_DEPTH; g++) begin : g_dout
        assign DOUT[g*LC_RF_DATA_WIDTH +: LC_RF_DATA_WIDTH] = rf[g];
    end
endmodule

// File: tb/tb_rf_ctrl_burst.sv
// Directed scoreboard bench for rf_ctrl_burst with a 20-deep file so range errors and wrap are reachable.
module tb_rf_ctrl_burst;
    localparam int D  = 20;
    localparam int AW = 8;
    localparam int W  = 24;

    logic           clk;
    logic           RESETn;
    logic           done;
    logic           err;
    logic [D-1:0]   updated;
    logic [W*D-1:0] dout;
    logic [1:0]     state;
    logic [D-1:0]   wp_mask;

    rf_ctrl_burst_if #(.ADDR_WIDTH(AW), .LC_RF_DATA_WIDTH(W)) bus ();

    rf_ctrl_burst #(.RF_DEPTH(D), .LC_RF_DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .CLK(clk),
        .RESETn(RESETn),
        .bus(bus),
        .DONE(done),
        .ERR(err),
        .UPDATED(updated),
        .DOUT(dout),
`ifdef RF_CTRL_WRITE_PROTECT_EN
        .WP_MASK(wp_mask),
`endif
        .STATE(state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // scoreboard state
    int             checks = 0;
    int             errors = 0;
    int             done_cnt = 0;
    int             exp_done = 0;
    logic           exp_err;
    logic [AW-1:0]  cur_addr;
    logic [W-1:0]   model [D];
    logic [W-1:0]   wbuf [4];
    logic [W-1:0]   exp_q [$];
    logic [D-1:0]   upd_q [$];
    logic [W-1:0]   mon_e;
    logic [D-1:0]   mon_u;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitors
    always @(negedge clk) begin
        if (RESETn) begin
            if (bus.OUT_VALID && bus.OUT_READY) begin
                if (exp_q.size() == 0) check("spurious_out", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("rd_data", bus.OUT_DATA, mon_e);
                end
            end else if (bus.OUT_VALID) begin
                if (exp_q.size() == 0) check("spurious_out", 1, 0);
                else check("rd_hold", bus.OUT_DATA, exp_q[0]);
            end
            if (updated != '0) begin
                if (upd_q.size() == 0) check("spurious_updated", 32'(updated), 0);
                else begin
                    mon_u = upd_q.pop_front();
                    check("updated", 32'(updated), 32'(mon_u));
                end
            end
            if (done) done_cnt++;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] len);
        bit ok = 0;
        bus.CMD_VALID = 1'b1;
        bus.CMD_WR    = wr;
        bus.CMD_ADDR  = a;
        bus.CMD_LEN   = len;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.CMD_READY) ok = 1;
            tick();
        end
        bus.CMD_VALID = 1'b0;
        check("cmd_accept", 32'(ok), 1);
    endtask

    task automatic write_beat(input logic [W-1:0] data, input bit gap);
        bit ok = 0;
        if (gap) begin
            bus.IN_VALID = 1'b0;
            tick();
        end
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = data;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.IN_READY) begin
                ok = 1;
                if (cur_addr < AW'(D) && !wp_mask[cur_addr[4:0]]) begin
                    model[cur_addr[4:0]] = data;
                    upd_q.push_back(D'(1) << cur_addr);
                end else begin
                    exp_err = 1'b1;
                end
                cur_addr = cur_addr + 1'b1;
            end
            tick();
        end
        bus.IN_VALID = 1'b0;
        check("in_accept", 32'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            if (bus.CMD_READY) ok = 1;
            else tick();
        end
        check("idle", 32'(ok), 1);
        check("done_cnt", done_cnt, exp_done);
        check("err", 32'(err), 32'(exp_err));
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input int n, input bit gaps);
        exp_err  = 1'b0;
        cur_addr = a;
        send_cmd(1'b1, a, AW'(n - 1));
        check("err_after_accept", 32'(err), 0);
        for (int i = 0; i < n; i++) write_beat(wbuf[i], gaps);
        exp_done++;
        wait_idle();
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input logic [AW-1:0] len);
        logic [AW-1:0] ra;
        exp_err = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            ra = a + AW'(i);
            if (ra < AW'(D)) exp_q.push_back(model[ra[4:0]]);
            else begin
                exp_q.push_back('0);
                exp_err = 1'b1;
            end
        end
        send_cmd(1'b0, a, len);
        check("err_after_accept", 32'(err), (a < AW'(D)) ? 32'd0 : 32'd1);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < D; i++) check(tag, dout[i*W +: W], model[i]);
    endtask

    // directed sequence
    initial begin
        RESETn        = 1'b0;
        bus.CMD_VALID = 1'b0;
        bus.CMD_WR    = 1'b0;
        bus.CMD_ADDR  = '0;
        bus.CMD_LEN   = '0;
        bus.IN_VALID  = 1'b0;
        bus.IN_DATA   = '0;
        bus.OUT_READY = 1'b0;
        exp_err       = 1'b0;
        cur_addr      = '0;
        wp_mask       = '0;
`ifdef RF_CTRL_WRITE_PROTECT_EN
        wp_mask       = 20'h00008;
`endif
        for (int i = 0; i < D; i++) model[i] = '0;

        // 1: reset state
        repeat (3) tick();
        RESETn = 1'b1;
        tick();
        check("rst_cmd_ready", 32'(bus.CMD_READY), 1);
        check("rst_in_ready", 32'(bus.IN_READY), 0);
        check("rst_out_valid", 32'(bus.OUT_VALID), 0);
        check("rst_out_data", bus.OUT_DATA, 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_updated", 32'(updated), 0);
        check("rst_state", 32'(state), 0);
        check_regs("rst_dout");

        // 2: write 0x10..0x12 with IN_VALID toggling
        wbuf[0] = 24'hAAAAAA; wbuf[1] = 24'h555555; wbuf[2] = 24'h123456;
        write_burst(8'h10, 3, 1'b1);
        check_regs("wr_dout");

        // 3: read 0x11..0x12 with a 3-cycle OUT_READY stall
        bus.OUT_READY = 1'b0;
        read_burst(8'h11, 8'd1);
        repeat (3) tick();
        bus.OUT_READY = 1'b1;
        exp_done++;
        wait_idle();
        check_regs("rd_dout");

        // 4: write running off the end of the file, then ERR clears on next accept
        wbuf[0] = 24'h111111; wbuf[1] = 24'h222222; wbuf[2] = 24'h333333; wbuf[3] = 24'h444444;
        write_burst(8'd18, 4, 1'b0);
        check_regs("oor_dout");
        read_burst(8'd0, 8'd0);
        exp_done++;
        wait_idle();

        // out-of-range read beat reads 0 and flags ERR
        read_burst(8'd19, 8'd1);
        exp_done++;
        wait_idle();

        // address wrap: 0xFF dropped, 0x00 written
        wbuf[0] = 24'hABCDEF; wbuf[1] = 24'h0F0F0F;
        write_burst(8'hFF, 2, 1'b0);
        check_regs("wrap_dout");

        // full-range read burst
        read_burst(8'd0, 8'hFF);
        exp_done++;
        wait_idle();

        // 5: reset mid-write after one of four beats
        exp_err  = 1'b0;
        cur_addr = 8'd5;
        send_cmd(1'b1, 8'd5, 8'd3);
        write_beat(24'h777777, 1'b0);
        tick();
        check("mid_reg5", dout[5*W +: W], 24'h777777);
        check("mid_reg6", dout[6*W +: W], 24'h000000);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 24'h888888;
        #2;
        RESETn = 1'b0;
        #1;
        bus.IN_VALID = 1'b0;
        for (int i = 0; i < D; i++) model[i] = '0;
        check_regs("mid_rst_dout");
        check("mid_rst_state", 32'(state), 0);
        check("mid_rst_cmd_ready", 32'(bus.CMD_READY), 1);
        check("mid_rst_updated", 32'(updated), 0);
        tick();
        tick();
        RESETn = 1'b1;
        tick();
        check_regs("post_rst_dout");
        check("post_rst_err", 32'(err), 0);

`ifdef RF_CTRL_WRITE_PROTECT_EN
        // 6: protected register 3 is skipped
        wbuf[0] = 24'd1; wbuf[1] = 24'd2; wbuf[2] = 24'd3;
        write_burst(8'd2, 3, 1'b0);
        check("wp_reg3", dout[3*W +: W], 24'd0);
        check_regs("wp_dout");
`endif

        tick();
        check("exp_q_empty", exp_q.size(), 0);
        check("upd_q_empty", upd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
